// File: rtl/cpu_result_dumper_pkg.sv
// Shared state encodings, tag layout and default run parameters for the result dumper.
package cpu_result_dumper_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SCAN_REG = 3'd1,
    ST_SCAN_MEM = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int          TAG_MEM       = 7;
  localparam logic [31:0] DEF_REG_MASK  = 32'hA000_0FFF;
  localparam int          DEF_END_COUNT = 600;
  localparam int          DEF_MEM_WORDS = 12;

  function automatic logic [7:0] reg_tag(input logic [4:0] idx);
    return {3'b000, idx};
  endfunction

  function automatic logic [7:0] mem_tag(input logic [6:0] widx);
    logic [7:0] t;
    t          = {1'b0, widx};
    t[TAG_MEM] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/cpu_result_dumper_mask_next.sv
// Finds the lowest set mask bit strictly above idx, or the lowest set bit overall when from_start=1.
module cpu_result_dumper_mask_next (
  input  logic [31:0] mask,
  input  logic [4:0]  idx,
  input  logic        from_start,
  output logic [4:0]  next_idx,
  output logic        found
);

  // Descending walk so the lowest qualifying bit is the last one written.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (from_start || (5'(i) > idx))) begin
        next_idx = 5'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_result_dumper.sv
// Halts the CPU after END_COUNT cycles, then streams selected registers and the first
// MEM_WORDS data-memory words as tagged beats on a valid/ready port.
module cpu_result_dumper
  import cpu_result_dumper_pkg::*;
#(
  parameter int          END_COUNT = DEF_END_COUNT,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] REG_MASK  = DEF_REG_MASK,
  parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        cpu_halt_o,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [31:0] dm_addr_o,
  input  logic [31:0] dm_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [7:0]  dump_tag_o,
  output logic [31:0] dump_data_o,
  output logic        done_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx;
  logic [6:0]       widx;
  logic             halt;
  logic             valid;
  logic [7:0]       tag;
  logic [31:0]      data;
  logic             done;

  logic [4:0] first_idx;
  logic       first_found;
  logic [4:0] nxt_idx;
  logic       nxt_found;
  logic       slot_free;

  cpu_result_dumper_mask_next u_first (
    .mask       (REG_MASK),
    .idx        (5'd0),
    .from_start (1'b1),
    .next_idx   (first_idx),
    .found      (first_found)
  );

  cpu_result_dumper_mask_next u_next (
    .mask       (REG_MASK),
    .idx        (idx),
    .from_start (1'b0),
    .next_idx   (nxt_idx),
    .found      (nxt_found)
  );

  assign slot_free = !valid || dump_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
      idx   <= '0;
      widx  <= '0;
      halt  <= 1'b0;
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(END_COUNT - 1)) begin
            halt <= 1'b1;
            widx <= '0;
            if (first_found) begin
              idx   <= first_idx;
              state <= ST_SCAN_REG;
            end else begin
              state <= ST_SCAN_MEM;
            end
          end
        end
        ST_SCAN_REG: begin
          if (slot_free) begin
            valid <= 1'b1;
            tag   <= reg_tag(idx);
            data  <= rf_data_i;
            if (nxt_found) begin
              idx <= nxt_idx;
            end else begin
              widx  <= '0;
              state <= (MEM_WORDS == 0) ? ST_DRAIN : ST_SCAN_MEM;
            end
          end
        end
        ST_SCAN_MEM: begin
          // An empty memory window passes straight through without producing a beat.
          if (MEM_WORDS == 0) begin
            state <= ST_DRAIN;
          end else if (slot_free) begin
            valid <= 1'b1;
            tag   <= mem_tag(widx);
            data  <= dm_data_i;
            if (widx == 7'(MEM_WORDS - 1)) begin
              state <= ST_DRAIN;
            end else begin
              widx <= widx + 7'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (slot_free) begin
            valid <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign cpu_halt_o   = halt;
  assign rf_addr_o    = idx;
  assign dm_addr_o    = {23'd0, widx, 2'b00};
  assign dump_valid_o = valid;
  assign dump_tag_o   = tag;
  assign dump_data_o  = data;
  assign done_o       = done;

endmodule

// File: tb/tb_cpu_result_dumper.sv
// Bench for cpu_result_dumper: three parameterisations share clock and reset, with
// random register/memory contents checked against an expected beat list.
module tb_cpu_result_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [31:0] rf_mem [32];
  logic [31:0] dm_mem [128];

  logic        halt_m, vld_m, rdy_m, done_m;
  logic [4:0]  rf_addr_m;
  logic [31:0] rf_data_m, dm_addr_m, dm_data_m, dat_m;
  logic [7:0]  tag_m;

  logic        halt_a, vld_a, rdy_a, done_a;
  logic [4:0]  rf_addr_a;
  logic [31:0] rf_data_a, dm_addr_a, dm_data_a, dat_a;
  logic [7:0]  tag_a;

  logic        halt_b, vld_b, rdy_b, done_b;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_b, dm_addr_b, dm_data_b, dat_b;
  logic [7:0]  tag_b;

  assign rf_data_m = rf_mem[rf_addr_m];
  assign dm_data_m = dm_mem[dm_addr_m[8:2]];
  assign rf_data_a = rf_mem[rf_addr_a];
  assign dm_data_a = dm_mem[dm_addr_a[8:2]];
  assign rf_data_b = rf_mem[rf_addr_b];
  assign dm_data_b = dm_mem[dm_addr_b[8:2]];

  cpu_result_dumper u_m (
    .clk_i(clk), .rst_i(rst_n), .cpu_halt_o(halt_m),
    .rf_addr_o(rf_addr_m), .rf_data_i(rf_data_m),
    .dm_addr_o(dm_addr_m), .dm_data_i(dm_data_m),
    .dump_valid_o(vld_m), .dump_ready_i(rdy_m),
    .dump_tag_o(tag_m), .dump_data_o(dat_m), .done_o(done_m)
  );

  cpu_result_dumper #(.END_COUNT(8), .REG_MASK(32'h0000_0003), .MEM_WORDS(2)) u_a (
    .clk_i(clk), .rst_i(rst_n), .cpu_halt_o(halt_a),
    .rf_addr_o(rf_addr_a), .rf_data_i(rf_data_a),
    .dm_addr_o(dm_addr_a), .dm_data_i(dm_data_a),
    .dump_valid_o(vld_a), .dump_ready_i(rdy_a),
    .dump_tag_o(tag_a), .dump_data_o(dat_a), .done_o(done_a)
  );

  cpu_result_dumper #(.END_COUNT(5), .REG_MASK(32'h0000_0000), .MEM_WORDS(0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .cpu_halt_o(halt_b),
    .rf_addr_o(rf_addr_b), .rf_data_i(rf_data_b),
    .dm_addr_o(dm_addr_b), .dm_data_i(dm_data_b),
    .dump_valid_o(vld_b), .dump_ready_i(rdy_b),
    .dump_tag_o(tag_b), .dump_data_o(dat_b), .done_o(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", nm, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom();
    for (int i = 0; i < 128; i++) dm_mem[i] = $urandom();
  endtask

  // Expected dump: every set mask bit in ascending order, then memory words 0..words-1.
  task automatic build_exp(input logic [31:0] mask, input int words);
    exp_q.delete();
    for (int i = 0; i < 32; i++)
      if (mask[i]) exp_q.push_back({8'(i), rf_mem[i]});
    for (int w = 0; w < words; w++)
      exp_q.push_back({8'h80 | 8'(w), dm_mem[w]});
  endtask

  task automatic check_reset_vals(input string ph);
    chk({ph, "_halt"},    32'(halt_m), 32'd0);
    chk({ph, "_valid"},   32'(vld_m), 32'd0);
    chk({ph, "_tag"},     32'(tag_m), 32'd0);
    chk({ph, "_data"},    dat_m, 32'd0);
    chk({ph, "_done"},    32'(done_m), 32'd0);
    chk({ph, "_rf_addr"}, 32'(rf_addr_m), 32'd0);
    chk({ph, "_dm_addr"}, dm_addr_m, 32'd0);
    chk({ph, "_a_halt"},  32'(halt_a), 32'd0);
    chk({ph, "_b_done"},  32'(done_b), 32'd0);
  endtask

  task automatic wait_halt(input int base, output int edges);
    edges = base;
    while (!halt_m && edges < 1000) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Consumes the main dump; entered #1 after the edge on which halt rose.
  task automatic run_dump(input bit rnd, input bit abort, output int beats);
    int          hold = 0;
    int          cyc = 0;
    int          mem_acc = 0;
    bit          fin = 0;
    bit          pv = 0, pr = 0, pacc = 0, acc;
    logic [7:0]  pt = '0;
    logic [31:0] pd = '0, pdm = '0;
    logic [4:0]  prf = '0;
    beats = 0;
    chk("first_valid_after_halt", 32'(vld_m), 32'd0);
    while (!fin && cyc < 400) begin
      cyc++;
      if (rnd && vld_m && tag_m == 8'h05 && hold < 3) begin
        rdy_m = 1'b0;
        hold++;
      end else if (rnd && vld_m && tag_m == 8'h05) begin
        rdy_m = 1'b1;
      end else begin
        rdy_m = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (pv && !pr) begin
        chk("stall_valid",   32'(vld_m), 32'd1);
        chk("stall_tag",     32'(tag_m), 32'(pt));
        chk("stall_data",    dat_m, pd);
        chk("stall_rf_addr", 32'(rf_addr_m), 32'(prf));
        chk("stall_dm_addr", dm_addr_m, pdm);
      end
      if (pacc && exp_q.size() > 0) chk("throughput_valid", 32'(vld_m), 32'd1);
      chk("halt_held", 32'(halt_m), 32'd1);
      acc = vld_m && rdy_m;
      if (vld_m && exp_q.size() == 0) begin
        chk("extra_beat", 32'(vld_m), 32'd0);
      end else if (acc) begin
        chk("beat_tag",  32'(tag_m), 32'(exp_q[0].tag));
        chk("beat_data", dat_m, exp_q[0].data);
        if (tag_m[7]) mem_acc++;
        void'(exp_q.pop_front());
        beats++;
      end
      if (done_m) begin
        chk("done_after_last_beat", 32'(pacc), 32'd1);
        chk("done_no_valid", 32'(vld_m), 32'd0);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        fin = 1;
      end else begin
        pv = vld_m; pr = rdy_m; pt = tag_m; pd = dat_m;
        prf = rf_addr_m; pdm = dm_addr_m; pacc = acc;
        @(posedge clk); #1;
        if (abort && mem_acc >= 4) begin
          rst_n = 1'b0;
          #1;
          check_reset_vals("async_reset");
          return;
        end
      end
    end
    if (!fin) chk("done_timeout", 32'(done_m), 32'd1);
  endtask

  initial begin
    int   edges;
    int   beats;
    logic [7:0] a_tags [4];
    a_tags[0] = 8'h00; a_tags[1] = 8'h01; a_tags[2] = 8'h80; a_tags[3] = 8'h81;

    rdy_m = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    rst_n = 1'b1;
    fill_mem();
    #3 rst_n = 1'b0;
    #1 check_reset_vals("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-exact view of the two small configurations.
    edges = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      edges++;
      chk("a_halt",  32'(halt_a), 32'(k >= 8));
      chk("a_valid", 32'(vld_a), 32'(k >= 9 && k <= 12));
      if (k >= 9 && k <= 12) begin
        chk("a_tag",  32'(tag_a), 32'(a_tags[k-9]));
        chk("a_data", dat_a, (k <= 10) ? rf_mem[k-9] : dm_mem[k-11]);
      end
      chk("a_done",  32'(done_a), 32'(k >= 13));
      chk("b_halt",  32'(halt_b), 32'(k >= 5));
      chk("b_valid", 32'(vld_b), 32'd0);
      chk("b_done",  32'(done_b), 32'(k >= 7));
      chk("m_halt_low", 32'(halt_m), 32'd0);
    end
    chk("a_rf_addr_end", 32'(rf_addr_a), 32'd1);
    chk("a_dm_addr_end", dm_addr_a, 32'h4);
    chk("b_rf_addr_end", 32'(rf_addr_b), 32'd0);
    chk("b_dm_addr_end", dm_addr_b, 32'h0);

    // Run 1: default configuration, random backpressure with a held tag-05 beat.
    wait_halt(edges, edges);
    chk("m_halt_edge_run1", edges, 32'd600);
    build_exp(32'hA000_0FFF, 12);
    run_dump(1'b1, 1'b0, beats);
    chk("beats_run1", beats, 32'd26);
    chk("dm_addr_end_run1", dm_addr_m, 32'h2C);
    chk("rf_addr_end_run1", 32'(rf_addr_m), 32'd31);

    // Run 2: reset in the middle of the memory scan.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_vals("reset2");
    fill_mem();
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(0, edges);
    chk("m_halt_edge_run2", edges, 32'd600);
    build_exp(32'hA000_0FFF, 12);
    run_dump(1'b0, 1'b1, beats);

    // Run 3: full re-run after the mid-scan reset, ready held high.
    fill_mem();
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(0, edges);
    chk("m_halt_edge_run3", edges, 32'd600);
    build_exp(32'hA000_0FFF, 12);
    run_dump(1'b0, 1'b0, beats);
    chk("beats_run3", beats, 32'd26);
    chk("dm_addr_end_run3", dm_addr_m, 32'h2C);
    chk("rf_addr_end_run3", 32'(rf_addr_m), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
